// File: rtl/spi_master_gen_if.sv
// rtl/spi_master_gen_if.sv - command bus between the register block and the SPI master
interface spi_master_gen_if #(
    parameter int DATA_W = 16
) ();
    localparam int NB_W = $clog2(DATA_W + 1);

    logic              go;
    logic [DATA_W-1:0] data_i;
    logic [NB_W-1:0]   nbits;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_o;

    modport master (output go, data_i, nbits, input busy, done, data_o);
    modport slave  (input go, data_i, nbits, output busy, done, data_o);
endinterface

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - SPI master, 1..DATA_W bit words, four modes, MSB/LSB first, auto/manual CS
module spi_master_gen #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8,
    parameter int CS_N   = 4,
    localparam int SEL_W = (CS_N > 1) ? $clog2(CS_N) : 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              cs_pol,
  input  logic              auto_cs,
  input  logic              cs_man,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [DIV_W-1:0]  clk_div,
  spi_master_gen_if.slave   bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_N-1:0]   cs
);
  localparam int NB_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] tx_s;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] data_o_r;
  logic [DATA_W-1:0] rx_bit;
  logic [NB_W-1:0]   n_s;
  logic [NB_W-1:0]   n_in;
  logic [NB_W-1:0]   cur_bit;
  logic [NB_W-1:0]   rx_pos;
  logic [NB_W:0]     half;
  logic [DIV_W-1:0]  div_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [SEL_W-1:0]  sel_s;
  logic [SEL_W-1:0]  sel_now;
  logic              cpol_s, cpha_s, lsb_s, auto_s, pol_s;
  logic              sclk_r, mosi_r, done_r;
  logic              tick, last_bit, cs_on, pol_now;

  // Wire bit k of a word in transmit order (k=0 is the first bit on the line).
  function automatic logic pick(input logic [DATA_W-1:0] w, input logic [NB_W-1:0] n,
                                input logic lsb, input logic [NB_W-1:0] k);
    logic [NB_W-1:0]   p;
    logic [DATA_W-1:0] sh;
    p  = lsb ? k : n - k - NB_W'(1);
    sh = w >> p;
    return sh[0];
  endfunction

  assign n_in     = (bus.nbits == '0 || bus.nbits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : bus.nbits;
  assign cur_bit  = half[NB_W:1];
  assign tick     = (div_cnt == div_s);
  assign last_bit = half[0] && (cur_bit == n_s - NB_W'(1));
  assign rx_pos   = lsb_s ? cur_bit : n_s - cur_bit - NB_W'(1);
  assign rx_bit   = {{(DATA_W-1){1'b0}}, miso} << rx_pos;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_s     <= '0;
      rx       <= '0;
      data_o_r <= '0;
      n_s      <= '0;
      half     <= '0;
      div_s    <= '0;
      div_cnt  <= '0;
      sel_s    <= '0;
      cpol_s   <= 1'b0;
      cpha_s   <= 1'b0;
      lsb_s    <= 1'b0;
      auto_s   <= 1'b0;
      pol_s    <= 1'b0;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            state   <= SETUP;
            tx_s    <= bus.data_i;
            n_s     <= n_in;
            cpol_s  <= cpol;
            cpha_s  <= cpha;
            lsb_s   <= lsb_first;
            div_s   <= clk_div;
            sel_s   <= cs_sel;
            auto_s  <= auto_cs;
            pol_s   <= cs_pol;
            div_cnt <= '0;
            half    <= '0;
            rx      <= '0;
            sclk_r  <= cpol;
            // Mode 0/2 slaves sample on the first edge, so bit 0 must already be on the line.
            mosi_r  <= cpha ? 1'b0 : pick(bus.data_i, n_in, lsb_first, '0);
          end
        end
        SETUP: begin
          if (tick) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            half    <= half + (NB_W+1)'(1);
            if (!half[0]) begin
              sclk_r <= ~cpol_s;
              if (!cpha_s) rx <= rx | rx_bit;
              else         mosi_r <= pick(tx_s, n_s, lsb_s, cur_bit);
            end else begin
              sclk_r <= cpol_s;
              if (cpha_s)         rx <= rx | rx_bit;
              else if (!last_bit) mosi_r <= pick(tx_s, n_s, lsb_s, cur_bit + NB_W'(1));
              if (last_bit) state <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          if (tick) begin
            div_cnt  <= '0;
            state    <= IDLE;
            data_o_r <= rx;
            done_r   <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // Manual CS stays live at all times; polarity and line index are frozen while busy.
  always_comb begin
    cs_on   = 1'b0;
    pol_now = cs_pol;
    sel_now = cs_sel;
    if (state == IDLE) begin
      cs_on = !auto_cs && cs_man;
    end else begin
      pol_now = pol_s;
      sel_now = sel_s;
      cs_on   = auto_s ? 1'b1 : cs_man;
    end
    cs = {CS_N{~pol_now}};
    if (cs_on) cs = cs ^ (CS_N'(1) << sel_now);
  end

  assign sclk       = (state == IDLE) ? cpol : sclk_r;
  assign mosi       = (state == IDLE) ? 1'b0 : mosi_r;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.data_o = data_o_r;
endmodule
